izh_spike_encoder: RTL and testbench

Downstream stage of the Izhikevich neuron core. Each step it samples the neuron's IEEE-754 single-precision membrane potential and compares it against a threshold. On a spike it pulses the neuron's reset request and queues a timestamped spike event into a small FIFO. A valid/ready interface drains that FIFO toward the spike router.

---
 rtl/izh_pkg.sv | 24 ++
 rtl/izh_spike_encoder_if.sv | 23 ++
 rtl/izh_spike_encoder_fp32_ge.sv | 39 +++
 rtl/izh_spike_encoder.sv | 107 ++++++++++
 tb/tb_izh_spike_encoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/izh_pkg.sv
// Shared fp32 field constants, encoder state encoding and the spike event payload
// for the Izhikevich neuron pipeline.
package izh_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_W   = 23;

  localparam logic [31:0] FP32_30 = 32'h41F0_0000;

  localparam int unsigned EV_TS_W = 16;

  typedef enum logic {
    ARMED = 1'b0,
    REFR  = 1'b1
  } state_t;

  // Spike event as seen by the router: the step index at which the neuron fired
  typedef struct packed {
    logic [EV_TS_W-1:0] ts;
  } spike_ev_t;

endpackage

// File: rtl/izh_spike_encoder_if.sv
// Step input and spike-event stream between the neuron core, the encoder and the router.
interface izh_spike_encoder_if #(
  parameter int unsigned TS_W = 16
);
  logic            step_valid;
  logic [31:0]     v_in;
  logic            spike;
  logic            ev_valid;
  logic            ev_ready;
  logic [TS_W-1:0] ev_time;
  logic            ovf;
  logic            refractory;

  modport master (
    input  step_valid, v_in, ev_ready,
    output spike, ev_valid, ev_time, ovf, refractory
  );

  modport slave (
    output step_valid, v_in, ev_ready,
    input  spike, ev_valid, ev_time, ovf, refractory
  );
endinterface

// File: rtl/izh_spike_encoder_fp32_ge.sv
// Combinational fp32 a >= b: NaN on either side is false, -0 equals +0, infinities
// order naturally through their bit patterns.
module fp32_ge
  import izh_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ge_c
);

  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic [30:0] mag_a;
  logic [30:0] mag_b;

  always_comb begin
    a_nan     = (a[EXP_MSB:EXP_LSB] == '1) && (a[MANT_W-1:0] != '0);
    b_nan     = (b[EXP_MSB:EXP_LSB] == '1) && (b[MANT_W-1:0] != '0);
    mag_a     = a[SIGN_BIT-1:0];
    mag_b     = b[SIGN_BIT-1:0];
    both_zero = (mag_a == '0) && (mag_b == '0);
    ge_c      = 1'b0;
    if (a_nan || b_nan) begin
      ge_c = 1'b0;
    end else if (both_zero) begin
      ge_c = 1'b1;
    end else begin
      // sign-magnitude: negative values order inversely by magnitude
      unique case ({a[SIGN_BIT], b[SIGN_BIT]})
        2'b00:   ge_c = (mag_a >= mag_b);
        2'b11:   ge_c = (mag_a <= mag_b);
        2'b01:   ge_c = 1'b1;
        default: ge_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/izh_spike_encoder.sv
// Threshold-crossing spike encoder: fires the neuron reset pulse, applies a refractory
// window and queues timestamped spike events in a small FIFO toward the router.
module izh_spike_encoder
  import izh_pkg::*;
#(
  parameter logic [31:0] THRESH = FP32_30,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned REFRAC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  izh_spike_encoder_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = (REFRAC > 1) ? $clog2(REFRAC) : 1;

  state_t          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q, wr_d, rd_d;
  logic [TS_W-1:0] head_d;
  logic [TS_W-1:0] ev_time_q;
  logic            ge_c, fire, pop, push, full;
  logic            spike_q, ev_valid_q, ovf_q, refr_q;

  fp32_ge u_ge (
    .a    (bus.v_in),
    .b    (THRESH),
    .ge_c (ge_c)
  );

  // Refractory FSM: REFR swallows REFRAC steps before re-arming
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    fire    = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (bus.step_valid && ge_c) begin
          fire = 1'b1;
          if (REFRAC != 0) begin
            state_d = REFR;
            rcnt_d  = RW'(REFRAC - 1);
          end
        end
      end
      REFR: begin
        if (bus.step_valid) begin
          if (rcnt_q == '0) state_d = ARMED;
          else              rcnt_d  = rcnt_q - RW'(1);
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // FIFO control; a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop    = ev_valid_q && bus.ev_ready;
    push   = fire && (!full || pop);
    rd_d   = rd_q + PW'(pop);
    wr_d   = wr_q + PW'(push);
    head_d = (push && (wr_q[AW-1:0] == rd_d[AW-1:0])) ? ts_q : mem_q[rd_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= ts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARMED;
      rcnt_q     <= '0;
      ts_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      spike_q    <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_time_q  <= '0;
      ovf_q      <= 1'b0;
      refr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      spike_q    <= fire;
      ev_valid_q <= (wr_d != rd_d);
      ovf_q      <= ovf_q | (fire && full && !pop);
      refr_q     <= (state_d == REFR);
      if (bus.step_valid) ts_q      <= ts_q + TS_W'(1);
      if (wr_d != rd_d)   ev_time_q <= head_d;
    end
  end

  assign bus.spike      = spike_q;
  assign bus.ev_valid   = ev_valid_q;
  assign bus.ev_time    = ev_time_q;
  assign bus.ovf        = ovf_q;
  assign bus.refractory = refr_q;

endmodule

// File: tb/tb_izh_spike_encoder.sv
// Bench for izh_spike_encoder: a 16-bit and a 4-bit timestamp instance run in lockstep
// against one queue-based reference model, with directed then random steps.
module tb_izh_spike_encoder;

  localparam int unsigned DEPTH = 8;
  localparam int          RF    = 2;

  localparam logic [31:0] F_30    = 32'h41F0_0000;
  localparam logic [31:0] F_40    = 32'h4220_0000;
  localparam logic [31:0] F_BELOW = 32'h41EF_FFFF;
  localparam logic [31:0] F_PINF  = 32'h7F80_0000;
  localparam logic [31:0] F_NINF  = 32'hFF80_0000;
  localparam logic [31:0] F_NAN   = 32'h7FC0_0000;
  localparam logic [31:0] F_M65   = 32'hC282_0000;

  logic        clk;
  logic        rst_n;
  logic        step_valid;
  logic [31:0] v_in;
  logic        ev_ready;

  int n_cmp = 0;
  int n_mis = 0;

  int unsigned ts_m;
  int          refr_m;
  bit          ovf_m;
  bit          spike_m;
  int unsigned q[$];

  izh_spike_encoder_if #(.TS_W(16)) b0 ();
  izh_spike_encoder_if #(.TS_W(4))  b1 ();

  assign b0.step_valid = step_valid;
  assign b0.v_in       = v_in;
  assign b0.ev_ready   = ev_ready;
  assign b1.step_valid = step_valid;
  assign b1.v_in       = v_in;
  assign b1.ev_ready   = ev_ready;

  izh_spike_encoder #(.TS_W(16), .DEPTH(DEPTH), .REFRAC(RF)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  izh_spike_encoder #(.TS_W(4), .DEPTH(DEPTH), .REFRAC(RF)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Real-valued reading of the fp32 word; NaN never reaches the threshold
  function automatic bit model_ge30(input logic [31:0] v);
    int  e;
    real mag;
    e = int'(v[30:23]);
    if (e == 255) return (v[22:0] == 23'd0) && !v[31];
    if (e == 0) mag = real'(v[22:0]) * (2.0 ** (-149));
    else        mag = (real'(v[22:0]) + 8388608.0) * (2.0 ** (e - 150));
    return (v[31] ? -mag : mag) >= 30.0;
  endfunction

  task automatic model_reset();
    ts_m    = 0;
    refr_m  = 0;
    ovf_m   = 1'b0;
    spike_m = 1'b0;
    q.delete();
  endtask

  task automatic model_edge(input bit sv, input logic [31:0] v, input bit rdy);
    bit pop;
    bit fire;
    pop  = rdy && (q.size() > 0);
    fire = sv && (refr_m == 0) && model_ge30(v);
    if (pop) void'(q.pop_front());
    if (fire) begin
      if (q.size() < DEPTH) q.push_back(ts_m);
      else                  ovf_m = 1'b1;
    end
    if (sv) begin
      if (refr_m > 0) refr_m--;
      else if (fire)  refr_m = RF;
      ts_m++;
    end
    spike_m = fire;
  endtask

  task automatic check_all();
    chk("spike",         32'(b0.spike),      32'(spike_m));
    chk("spike_w4",      32'(b1.spike),      32'(spike_m));
    chk("ev_valid",      32'(b0.ev_valid),   32'(q.size() > 0));
    chk("ev_valid_w4",   32'(b1.ev_valid),   32'(q.size() > 0));
    chk("ovf",           32'(b0.ovf),        32'(ovf_m));
    chk("ovf_w4",        32'(b1.ovf),        32'(ovf_m));
    chk("refractory",    32'(b0.refractory), 32'(refr_m > 0));
    chk("refractory_w4", 32'(b1.refractory), 32'(refr_m > 0));
    if (q.size() > 0) begin
      chk("ev_time",    32'(b0.ev_time), q[0] & 32'h0000_FFFF);
      chk("ev_time_w4", 32'(b1.ev_time), q[0] & 32'h0000_000F);
    end
  endtask

  task automatic step(input bit sv, input logic [31:0] v, input bit rdy);
    @(negedge clk);
    step_valid = sv;
    v_in       = v;
    ev_ready   = rdy;
    @(posedge clk);
    model_edge(sv, v, rdy);
    #1;
    check_all();
  endtask

  // Asserts reset wherever the caller is in the cycle and checks the immediate clear
  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    if (b0.ev_time !== 16'd0) chk("ev_time_rst", 32'(b0.ev_time), 32'd0);
    @(negedge clk);
    step_valid = 1'b0;
    ev_ready   = 1'b0;
    rst_n      = 1'b1;
  endtask

  function automatic logic [31:0] rand_v();
    case ($urandom_range(0, 8))
      0:       return $urandom;
      1:       return F_30;
      2:       return F_40;
      3:       return F_BELOW;
      4:       return F_PINF;
      5:       return F_NINF;
      6:       return F_NAN | 32'($urandom_range(0, 255));
      7:       return 32'h41F0_0001;
      default: return F_M65;
    endcase
  endfunction

  initial begin
    step_valid = 1'b0;
    v_in       = 32'd0;
    ev_ready   = 1'b0;
    rst_n      = 1'b1;
    #2;
    reset_pulse();

    // Exact threshold, refractory window, and the boundary values while armed
    step(1'b1, F_30, 1'b0);
    step(1'b1, F_40, 1'b0);
    step(1'b1, F_40, 1'b0);
    step(1'b1, F_40, 1'b0);
    step(1'b1, F_40, 1'b0);
    step(1'b1, F_BELOW, 1'b0);
    step(1'b1, F_PINF, 1'b0);
    step(1'b1, 32'd0, 1'b0);
    step(1'b1, 32'd0, 1'b0);
    step(1'b1, F_NAN, 1'b0);
    step(1'b1, F_M65, 1'b0);
    step(1'b1, F_NINF, 1'b0);
    step(1'b1, F_BELOW, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b1);

    // Fill to DEPTH, then push and pop in the same cycle on the full FIFO
    reset_pulse();
    for (int i = 0; i < 25; i++) step(1'b1, F_40, i == 24);
    repeat (10) step(1'b0, 32'd0, 1'b1);

    // Ten spikes into a stalled FIFO: two dropped, sticky ovf, in-order drain
    reset_pulse();
    for (int i = 0; i < 30; i++) step(1'b1, F_40, 1'b0);
    repeat (10) step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);

    // Timestamp wrap on the 4-bit instance, then reset in the middle of a drain
    reset_pulse();
    repeat (16) step(1'b1, 32'd0, 1'b0);
    step(1'b1, F_30, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, F_40, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    reset_pulse();
    step(1'b1, F_30, 1'b0);
    step(1'b0, 32'd0, 1'b0);

    // Random steps, values and back-pressure
    reset_pulse();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), rand_v(), 1'($urandom_range(0, 2) != 0));
    repeat (10) step(1'b0, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
